// File: rtl/parity_link_pkg.sv
// Shared definitions for the serial parity link (transmitter and receiver).
package parity_link_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } link_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_BIT_CYCLES = 4;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parity_serial_tx_parity_gen.sv
// Parity generator shared by the link transmitter and receiver.
module parity_gen #(
  parameter int unsigned WIDTH      = 8,
  parameter logic        ODD_PARITY = 1'b1
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  // Odd parity is the XNOR reduction, even parity the XOR reduction.
  always_comb begin
    parity = ODD_PARITY ? ~^data : ^data;
  end

endmodule

// File: rtl/parity_serial_tx.sv
// Serial transmitter: start bit, WIDTH data bits LSB first, parity bit, stop bit.
module parity_serial_tx
  import parity_link_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter logic        ODD_PARITY = 1'b1,
  parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             tx_out,
  output logic             busy
);

  localparam int unsigned CW = cnt_bits(BIT_CYCLES);
  localparam int unsigned BW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  link_state_e      state, state_nx;
  logic [CW-1:0]    cycle_cnt, cycle_cnt_nx;
  logic [BW-1:0]    bit_cnt, bit_cnt_nx;
  logic [WIDTH-1:0] shift, shift_nx, shifted;
  logic             par_bit, par_bit_nx, par_in;
  logic             tx_nx;
  logic             bit_done;

  parity_gen #(
    .WIDTH      (WIDTH),
    .ODD_PARITY (ODD_PARITY)
  ) u_parity_gen (
    .data   (data_in),
    .parity (par_in)
  );

  // Next-state, counters, shift register and next line level.
  always_comb begin
    state_nx     = state;
    cycle_cnt_nx = cycle_cnt;
    bit_cnt_nx   = bit_cnt;
    shift_nx     = shift;
    par_bit_nx   = par_bit;
    tx_nx        = tx_out;
    shifted      = shift >> 1;
    bit_done     = (cycle_cnt == CYC_LAST);

    if (state != IDLE) begin
      cycle_cnt_nx = bit_done ? '0 : cycle_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (valid_in) begin
          shift_nx     = data_in;
          par_bit_nx   = par_in;
          bit_cnt_nx   = '0;
          cycle_cnt_nx = '0;
          state_nx     = START;
          tx_nx        = LINE_START;
        end
      end
      START: begin
        if (bit_done) begin
          state_nx   = DATA;
          bit_cnt_nx = '0;
          tx_nx      = shift[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt == BIT_LAST) begin
            state_nx = PARITY;
            tx_nx    = par_bit;
          end else begin
            // Emit the bit that becomes shift[0] after this shift.
            shift_nx   = shifted;
            bit_cnt_nx = bit_cnt + 1'b1;
            tx_nx      = shifted[0];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_nx = STOP;
          tx_nx    = LINE_IDLE;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_nx = IDLE;
          tx_nx    = LINE_IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = LINE_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      tx_out    <= LINE_IDLE;
    end else begin
      state     <= state_nx;
      cycle_cnt <= cycle_cnt_nx;
      bit_cnt   <= bit_cnt_nx;
      shift     <= shift_nx;
      par_bit   <= par_bit_nx;
      tx_out    <= tx_nx;
    end
  end

  // Handshake and status decoded from the state register.
  always_comb begin
    ready_out = (state == IDLE);
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Scoreboard bench for parity_serial_tx: expected per-cycle line patterns are
// queued at accept time and compared when each frame ends.
module tb_parity_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d0, d1;
  logic [0:0] d2;
  logic       v0, v1, v2;
  logic       r0, r1, r2, t0, t1, t2, b0, b1, b2;

  logic [2:0] busy_v, tx_v, rdy_v;
  assign busy_v = {b2, b1, b0};
  assign tx_v   = {t2, t1, t0};
  assign rdy_v  = {r2, r1, r0};

  always #5 clk = ~clk;

  parity_serial_tx #(.WIDTH(8), .ODD_PARITY(1'b1), .BIT_CYCLES(4)) dut_odd (
    .clk(clk), .rst(rst), .data_in(d0), .valid_in(v0),
    .ready_out(r0), .tx_out(t0), .busy(b0));

  parity_serial_tx #(.WIDTH(8), .ODD_PARITY(1'b0), .BIT_CYCLES(4)) dut_even (
    .clk(clk), .rst(rst), .data_in(d1), .valid_in(v1),
    .ready_out(r1), .tx_out(t1), .busy(b1));

  parity_serial_tx #(.WIDTH(1), .ODD_PARITY(1'b1), .BIT_CYCLES(1)) dut_small (
    .clk(clk), .rst(rst), .data_in(d2), .valid_in(v2),
    .ready_out(r2), .tx_out(t2), .busy(b2));

  int    total = 0;
  int    bad   = 0;
  logic  mon_en = 1'b0;
  string exp_q[3][$];
  string cur[3];
  logic  pbusy[3];
  int    idle_cnt[3];
  int    last_gap[3];

  function automatic string expand(input string s, input int bc);
    string r = "";
    for (int k = 0; k < s.len(); k++)
      for (int j = 0; j < bc; j++)
        r = {r, s.substr(k, k)};
    return r;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  // Monitor: collect the line while busy, compare against the queue at frame end.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (rdy_v[i] !== ~busy_v[i]) begin
          bad++;
          $display("FAIL ready_vs_busy[%0d]: ready=%b busy=%b", i, rdy_v[i], busy_v[i]);
        end
        if (busy_v[i] === 1'b1) begin
          if (!pbusy[i]) begin
            last_gap[i] = idle_cnt[i];
            cur[i] = "";
          end
          cur[i] = {cur[i], (tx_v[i] === 1'b1) ? "1" : (tx_v[i] === 1'b0) ? "0" : "x"};
        end else begin
          total++;
          if (tx_v[i] !== 1'b1) begin
            bad++;
            $display("FAIL idle_line[%0d]: tx=%b expected 1", i, tx_v[i]);
          end
          if (pbusy[i]) begin
            total++;
            if (exp_q[i].size() == 0) begin
              bad++;
              $display("FAIL unexpected_frame[%0d]: got %s", i, cur[i]);
            end else begin
              string e;
              e = exp_q[i].pop_front();
              if (cur[i] != e) begin
                bad++;
                $display("FAIL frame[%0d]: got %s expected %s", i, cur[i], e);
              end
            end
            idle_cnt[i] = 0;
          end
          idle_cnt[i]++;
        end
        pbusy[i] = busy_v[i];
      end
    end
  end

  task automatic send(input int i, input logic [7:0] d, input string e, input bit hold);
    int n = 0;
    case (i)
      0: begin d0 = d;    v0 = 1'b1; end
      1: begin d1 = d;    v1 = 1'b1; end
      default: begin d2 = d[0:0]; v2 = 1'b1; end
    endcase
    while (rdy_v[i] !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL send_timeout[%0d]: ready stayed %b, expected 1", i, rdy_v[i]);
    end else begin
      @(posedge clk);
      exp_q[i].push_back(e);
      #1;
    end
    if (!hold) begin
      case (i)
        0: v0 = 1'b0;
        1: v1 = 1'b0;
        default: v2 = 1'b0;
      endcase
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      pbusy[i] = 1'b0; idle_cnt[i] = 0; last_gap[i] = -1; cur[i] = "";
    end
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset_tx", t0, 1'b1);
    check_bit("reset_busy", b0, 1'b0);
    check_bit("reset_ready", r0, 1'b1);
    check_bit("reset_tx_small", t2, 1'b1);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    send(0, 8'hA5, expand("01010010111", 4), 1'b0);
    send(0, 8'h01, expand("01000000001", 4), 1'b0);
    send(0, 8'h00, expand("00000000011", 4), 1'b0);
    send(1, 8'h01, expand("01000000011", 4), 1'b0);
    send(1, 8'h00, expand("00000000001", 4), 1'b0);

    // Back-to-back with data_in changed during the first frame.
    send(0, 8'h3C, expand("00011110011", 4), 1'b1);
    d0 = 8'hC3;
    send(0, 8'hC3, expand("01100001111", 4), 1'b0);
    @(negedge clk); #1;
    total++;
    if (last_gap[0] != 1) begin
      bad++;
      $display("FAIL b2b_gap: got %0d idle cycles expected 1", last_gap[0]);
    end

    // Reset in the middle of data bit 3 (two of its four cycles sent).
    send(0, 8'h3C, {"0000", "0000", "0000", "1111", "11"}, 1'b0);
    repeat (17) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_bit("midreset_tx", t0, 1'b1);
    check_bit("midreset_busy", b0, 1'b0);
    check_bit("midreset_ready", r0, 1'b1);
    rst = 1'b0;
    send(0, 8'hFF, expand("01111111111", 4), 1'b0);

    send(2, 8'h01, "0101", 1'b0);

    n = 0;
    while ((busy_v !== 3'b000 || exp_q[0].size() != 0 || exp_q[1].size() != 0 ||
            exp_q[2].size() != 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (exp_q[i].size() != 0) begin
        bad++;
        $display("FAIL drain[%0d]: %0d frames outstanding expected 0", i, exp_q[i].size());
      end
    end
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
